// File: rtl/read_pointer_handler_fwft_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | read_pointer_handler_fwft_if : read-side FIFO control bus (pointers, data) |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface read_pointer_handler_fwft_if #(
  parameter int DATA_WIDTH = 32
);
  logic [3:0]            graycoded_write_pointer;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [2:0]            read_pointer;
  logic [3:0]            graycoded_read_pointer;
  logic                  empty;
  logic [3:0]            fill_level;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  // master: the read-pointer handler, which sources the output stream
  modport master (
    input  graycoded_write_pointer,
    input  mem_rdata,
    input  out_ready,
    output read_pointer,
    output graycoded_read_pointer,
    output empty,
    output fill_level,
    output out_valid,
    output out_data
  );

  modport slave (
    output graycoded_write_pointer,
    output mem_rdata,
    output out_ready,
    input  read_pointer,
    input  graycoded_read_pointer,
    input  empty,
    input  fill_level,
    input  out_valid,
    input  out_data
  );
endinterface
`default_nettype wire

// File: rtl/read_pointer_handler_fwft.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | read_pointer_handler_fwft : async FIFO read domain with FWFT output reg    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module read_pointer_handler_fwft #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2   // 2 or 3
) (
  input  logic                        clk_rx,
  input  logic                        rst_rx,
  read_pointer_handler_fwft_if.master bus
);

  logic [3:0]            sync_q [SYNC_STAGES];
  logic [3:0]            synced_wptr_g;
  logic [3:0]            synced_wptr_b;
  logic [3:0]            read_counter;
  logic [3:0]            read_gray;
  logic [3:0]            graycoded_read_pointer_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  empty;
  logic                  take;
  logic                  load;

  // Plain flop chain: no logic between stages so each stage can resolve metastability
  always_ff @(posedge clk_rx) begin
    if (rst_rx) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 4'b0000;
      end
    end else begin
      sync_q[0] <= bus.graycoded_write_pointer;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign synced_wptr_g = sync_q[SYNC_STAGES-1];

  always_comb begin
    synced_wptr_b = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      synced_wptr_b[i] = ^(synced_wptr_g >> i);
    end
  end

  assign read_gray = read_counter ^ (read_counter >> 1);
  assign empty     = (read_gray == synced_wptr_g);
  assign take      = out_valid_q & bus.out_ready;
  assign load      = ~empty & (~out_valid_q | bus.out_ready);

  always_ff @(posedge clk_rx) begin
    if (rst_rx) begin
      read_counter             <= 4'd0;
      graycoded_read_pointer_q <= 4'b0000;
      out_valid_q              <= 1'b0;
      out_data_q               <= '0;
    end else begin
      // Registered so the write domain never samples the encoder's glitches
      graycoded_read_pointer_q <= read_gray;
      if (load) begin
        out_data_q   <= bus.mem_rdata;
        out_valid_q  <= 1'b1;
        read_counter <= read_counter + 4'd1;
      end else if (take) begin
        out_valid_q  <= 1'b0;
      end
    end
  end

  assign bus.read_pointer           = read_counter[2:0];
  assign bus.graycoded_read_pointer = graycoded_read_pointer_q;
  assign bus.empty                  = empty;
  assign bus.fill_level             = synced_wptr_b - read_counter;
  assign bus.out_valid              = out_valid_q;
  assign bus.out_data               = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_read_pointer_handler_fwft.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench: occupancy-level model compared every cycle, plus directed literal checks.
module tb_read_pointer_handler_fwft;
  localparam int DW = 32;
  localparam int SS = 2;

  logic clk_rx = 1'b0;
  logic rst_rx;
  always #5 clk_rx = ~clk_rx;

  read_pointer_handler_fwft_if #(.DATA_WIDTH(DW)) bus();
  read_pointer_handler_fwft #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk_rx(clk_rx), .rst_rx(rst_rx), .bus(bus));

  logic [DW-1:0] mem [8];
  logic [3:0]    wp_g;
  logic          ready;
  assign bus.graycoded_write_pointer = wp_g;
  assign bus.out_ready               = ready;
  assign bus.mem_rdata               = mem[bus.read_pointer];

  int checks = 0;
  int passed = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction
  // Decode by search over all codes rather than the xor chain
  function automatic logic [3:0] from_gray(input logic [3:0] g);
    for (int b = 0; b < 16; b++) if (to_gray(4'(b)) == g) return 4'(b);
    return 4'd0;
  endfunction

  // Model: write count seen SS edges late, read count, and output register contents
  logic [3:0]    m_hist [SS];
  logic [3:0]    m_rc, m_grp;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [3:0]    m_fill;
  logic          m_empty;
  assign m_fill  = from_gray(m_hist[SS-1]) - m_rc;
  assign m_empty = (m_fill == 4'd0);

  always @(posedge clk_rx) begin
    if (rst_rx) begin
      for (int i = 0; i < SS; i++) m_hist[i] <= 4'd0;
      m_rc <= 4'd0; m_grp <= 4'd0; m_valid <= 1'b0; m_data <= '0;
    end else begin
      m_hist[0] <= wp_g;
      for (int i = 1; i < SS; i++) m_hist[i] <= m_hist[i-1];
      m_grp <= to_gray(m_rc);
      if (!m_empty && (!m_valid || ready)) begin
        m_data <= mem[m_rc[2:0]]; m_valid <= 1'b1; m_rc <= m_rc + 4'd1;
      end else if (m_valid && ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  logic          chk_en = 1'b0;
  logic          sb_en  = 1'b0;
  logic [DW-1:0] exp_q [$];
  int            taken  = 0;
  logic [3:0]    prev_grp = 4'd0;
  logic          saw_wrap = 1'b0;

  always @(negedge clk_rx) begin
    if (chk_en) begin
      chk("empty",        64'(bus.empty),                  64'(m_empty));
      chk("fill_level",   64'(bus.fill_level),             64'(m_fill));
      chk("read_pointer", 64'(bus.read_pointer),           64'(m_rc[2:0]));
      chk("gray_rptr",    64'(bus.graycoded_read_pointer), 64'(m_grp));
      chk("out_valid",    64'(bus.out_valid),              64'(m_valid));
      chk("out_data",     64'(bus.out_data),               64'(m_data));
      if (sb_en && bus.out_valid && ready) begin
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("sb_order", 64'(bus.out_data), 64'(exp_q.pop_front()));
        taken++;
      end
      if (prev_grp == 4'b1000 && bus.graycoded_read_pointer == 4'b0000) saw_wrap <= 1'b1;
      prev_grp <= bus.graycoded_read_pointer;
    end
  end

  task automatic tick();
    @(posedge clk_rx); #1;
  endtask

  task automatic reset_cycles(input int n, input logic [3:0] wp);
    rst_rx = 1'b1; wp_g = wp; ready = 1'b0;
    repeat (n) tick();
    rst_rx = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int pushed;
    int budget;
    rst_rx = 1'b1; wp_g = 4'd0; ready = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    // Reset with a non-zero incoming pointer
    wp_g = 4'b0011;
    tick(); chk_en = 1'b1;
    @(negedge clk_rx);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_rp",    64'(bus.read_pointer), 64'd0);
    chk("rst_grp",   64'(bus.graycoded_read_pointer), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_fill",  64'(bus.fill_level), 64'd0);
    tick(); rst_rx = 1'b0;
    tick(); @(negedge clk_rx);
    chk("sync1_empty", 64'(bus.empty), 64'd1);
    tick(); @(negedge clk_rx);
    chk("sync2_empty", 64'(bus.empty), 64'd0);
    chk("sync2_fill",  64'(bus.fill_level), 64'd2);

    // Fall-through latency and hold under backpressure
    for (int i = 0; i < 8; i++) mem[i] = 32'hA5A5_0001;
    reset_cycles(2, 4'b0000);
    wp_g = 4'b0001;
    tick(); tick(); @(negedge clk_rx);
    chk("lat_e2_valid", 64'(bus.out_valid), 64'd0);
    tick();
    for (int i = 0; i < 8; i++) mem[i] = 32'hDEAD_BEEF;
    @(negedge clk_rx);
    chk("lat_e3_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_e3_data",  64'(bus.out_data), 64'h0000_0000_A5A5_0001);
    chk("lat_e3_rp",    64'(bus.read_pointer), 64'd1);
    chk("lat_e3_empty", 64'(bus.empty), 64'd1);
    repeat (10) begin
      tick(); @(negedge clk_rx);
      chk("hold_data",  64'(bus.out_data), 64'h0000_0000_A5A5_0001);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
    end

    // Back-to-back streaming of a full storage
    for (int i = 0; i < 8; i++) mem[i] = DW'(i);
    reset_cycles(1, 4'b0000);
    wp_g = 4'b1100; ready = 1'b1;
    tick(); tick(); @(negedge clk_rx);
    chk("strm_fill8", 64'(bus.fill_level), 64'd8);
    for (int k = 0; k < 8; k++) begin
      tick(); @(negedge clk_rx);
      chk("strm_data",  64'(bus.out_data), 64'(k));
      chk("strm_valid", 64'(bus.out_valid), 64'd1);
      chk("strm_fill",  64'(bus.fill_level), 64'(7 - k));
    end
    tick(); @(negedge clk_rx);
    chk("strm_drop", 64'(bus.out_valid), 64'd0);

    // Wrap: writer advances one Gray step per push
    w = 8; exp_q.delete(); taken = 0; sb_en = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      mem[w % 8] = 32'h1000 + DW'(n);
      exp_q.push_back(32'h1000 + DW'(n));
      w = (w + 1) % 16;
      wp_g = to_gray(4'(w));
    end
    budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(); @(negedge clk_rx); budget--;
    end
    chk("wrap_drained", 64'(exp_q.size()), 64'd0);
    chk("wrap_taken",   64'(taken), 64'd20);
    tick(); tick(); @(negedge clk_rx);
    chk("wrap_rp",   64'(bus.read_pointer), 64'd4);
    chk("wrap_grp",  64'(bus.graycoded_read_pointer), 64'b1010);
    chk("wrap_seen", 64'(saw_wrap), 64'd1);

    // Random backpressure over 100 words
    taken = 0; pushed = 0; budget = 3000;
    while ((pushed < 100 || exp_q.size() != 0) && budget > 0) begin
      tick();
      ready = 1'($urandom_range(0, 1));
      if (pushed < 100 && ((4'(w) - m_rc) & 4'hF) < 4'd8) begin
        mem[w % 8] = 32'h2000 + DW'(pushed);
        exp_q.push_back(32'h2000 + DW'(pushed));
        pushed++;
        w = (w + 1) % 16;
        wp_g = to_gray(4'(w));
      end
      budget--;
    end
    @(negedge clk_rx);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_taken",   64'(taken), 64'd100);
    sb_en = 1'b0; ready = 1'b0;

    // Mid-stream reset with a valid word and fill_level 5
    reset_cycles(1, 4'b0000);
    wp_g = 4'b0101;
    tick(); tick(); tick(); @(negedge clk_rx);
    chk("mid_valid_pre", 64'(bus.out_valid), 64'd1);
    chk("mid_fill_pre",  64'(bus.fill_level), 64'd5);
    @(posedge clk_rx); #1;
    rst_rx = 1'b1; wp_g = 4'b0000; ready = 1'b1;
    tick(); rst_rx = 1'b0; ready = 1'b0;
    @(negedge clk_rx);
    chk("mid_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rp",    64'(bus.read_pointer), 64'd0);
    chk("mid_grp",   64'(bus.graycoded_read_pointer), 64'd0);
    chk("mid_empty", 64'(bus.empty), 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/read_pointer_handler_fwft.md
Name: read_pointer_handler_fwft

Overview:
Read-domain control for the 8-entry async FIFO. It is the downstream counterpart of the write-side pointer logic.
- Synchronizes the Gray-coded write pointer into clk_rx and derives empty and fill level.
- Drives the storage read address and advances a 4-bit read counter.
- Presents data through a first-word-fall-through output register with a valid/ready handshake.
- Exports a registered Gray read pointer for the write domain's full check.

Parameters:
DATA_WIDTH, 32, width of FIFO storage word and out_data.
SYNC_STAGES, 2, flops in write-pointer synchronizer chain (legal: 2 or 3).

Ports:
clk_rx  input  1  read-domain clock
rst_rx  input  1  synchronous, active-high reset
graycoded_write_pointer  input  4  Gray write pointer from write domain (asynchronous to clk_rx)
mem_rdata  input  DATA_WIDTH  storage word at read_pointer (combinational read, valid in same cycle)
read_pointer  output  3  storage read address = read_counter[2:0]
graycoded_read_pointer  output  4  registered Gray read pointer, to write-domain synchronizer
empty  output  1  no unread entry in storage (output register excluded)
fill_level  output  4  entries in storage not yet loaded to output register, 0..8
out_valid  output  1  out_data holds a valid word
out_data  output  DATA_WIDTH  head-of-FIFO word
out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- One clock, clk_rx. Synchronous active-high reset rst_rx. All state updates on posedge clk_rx.
- Reset values:
  - read_counter = 0, so read_pointer = 0.
  - graycoded_read_pointer = 4'b0000.
  - All synchronizer stages = 4'b0000.
  - out_valid = 0.
  - out_data = 0.
  - Hence empty = 1 and fill_level = 0 after reset.
- Synchronizer: graycoded_write_pointer is shifted through SYNC_STAGES flops. The last stage is synced_wptr_g. No logic between stages.
- Gray encode: g = b ^ (b >> 1). Gray decode of synced_wptr_g gives synced_wptr_b: bit3 = g3; bit i = bit(i+1) ^ g(i).
- empty = (gray(read_counter) == synced_wptr_g). Combinational.
- fill_level = (synced_wptr_b - read_counter) mod 16. Combinational. Never exceeds 8 in legal operation.
- take = out_valid & out_ready.
- load = ~empty & (~out_valid | out_ready).
- On load:
  - out_data <= mem_rdata.
  - out_valid <= 1.
  - read_counter <= read_counter + 1 (mod 16).
- On take without load: out_valid <= 0. out_data holds its value.
- Neither take nor load: all state held. out_data must stay stable while out_valid=1 and out_ready=0.
- Simultaneous take and load: back-to-back transfer, one word per cycle. out_valid stays 1.
- graycoded_read_pointer <= gray(read_counter) every cycle. It lags read_counter by one cycle, which keeps the encoder combinational path off the CDC boundary.
- Latency:
  - synced_wptr_g reflects a write-pointer change SYNC_STAGES edges after it is stable at the input.
  - out_valid rises on the first edge where empty=0 and the output register is free.
  - Default: first word visible 3 clk_rx edges after the write pointer changes.
- Wrap-around: read_counter 15 -> 0, Gray 4'b1000 -> 4'b0000, read_pointer 7 -> 0. Empty compares full 4-bit Gray, so no empty/full aliasing.
- Empty storage with output register valid: empty=1, out_valid=1. A take drops out_valid. No read_counter change.
- out_ready while out_valid=0: ignored. No underflow; read_counter never passes synced write pointer.
- Reset mid-operation: any word in the output register is discarded. Reset values apply on that edge regardless of out_ready or input pointer. The write domain must be reset together.

Test Plan:
- Reset: assert rst_rx 2 cycles with graycoded_write_pointer=4'b0011 -> during/after edge, out_valid=0, read_pointer=0, graycoded_read_pointer=0, empty=1, fill_level=0. After release, empty=0 and fill_level=2 by the 2nd edge.
- Fall-through latency: from reset, hold out_ready=0, mem_rdata=32'hA5A5_0001, step write pointer 0000->0001 -> out_valid=1 on 3rd edge, out_data=32'hA5A5_0001, read_pointer=1, empty=1 next. out_data stable 10 cycles while out_ready=0.
- Back-to-back streaming: write pointer at Gray of 8 (4'b1100), out_ready=1 constantly, mem_rdata=address -> out_data sequence 0..7 on 8 consecutive cycles. After the first fill, fill_level steps 8->0 as read_counter advances. out_valid drops one cycle after last take.
- Wrap: 20 words streamed with the write pointer advancing in step (one Gray step per push) -> read_pointer wraps 7->0 and graycoded_read_pointer passes 4'b1000->4'b0000. No spurious empty deassertion; data order preserved.
- Backpressure: random out_ready (50%) over 100 words -> every word delivered once in order, none while out_valid=0. graycoded_read_pointer always the Gray of read_counter one cycle earlier.
- Mid-stream reset: rst_rx for 1 cycle while out_valid=1 and fill_level=5 -> next cycle out_valid=0, read_counter=0, graycoded_read_pointer=0.
